// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the RV32I ALU issue slice.
// Contents:
//   - ALU control codes
//   - opcode constants
//   - skid-buffer state encoding
//   - immediate format selector
//   - decoded-entry struct
// The immediate is not part of the struct because its width is a module parameter.
package riscv_pkg;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_NOR     = 4'b1100;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        IMM_NONE = 2'b00,
        IMM_I    = 2'b01,
        IMM_S    = 2'b10,
        IMM_B    = 2'b11
    } imm_fmt_t;

    typedef struct packed {
        logic [3:0] alu_ctl;
        logic       use_imm;
        logic       is_branch;
        logic       illegal;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } dec_t;

endpackage

// File: rtl/riscv_alu_decode.sv
// riscv_alu_decode
// Purely combinational decode of an RV32I instruction word into ALU control
// fields plus a sign-extended immediate.
// Ports:
//   instr : 32-bit instruction word
//   dec   : ALU control, use_imm, is_branch, illegal, rs1/rs2/rd
//   imm   : sign-extended I/S/B immediate; 0 for R-type and illegal words
module riscv_alu_decode
    import riscv_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  logic [31:0]          instr,
    output dec_t                 dec,
    output logic [REG_WIDTH-1:0] imm
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    imm_fmt_t   fmt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        dec.alu_ctl   = ALU_ILLEGAL;
        dec.use_imm   = 1'b0;
        dec.is_branch = 1'b0;
        dec.illegal   = 1'b1;
        dec.rs1       = instr[19:15];
        dec.rs2       = instr[24:20];
        dec.rd        = instr[11:7];
        fmt           = IMM_NONE;

        case (opcode)
            OP_RTYPE: begin
                dec.illegal = 1'b0;
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000)      dec.alu_ctl = ALU_ADD;
                        else if (funct7 == 7'b0100000) dec.alu_ctl = ALU_SUB;
                        else                           dec.illegal = 1'b1;
                    end
                    3'b111:  dec.alu_ctl = ALU_AND;
                    3'b110:  dec.alu_ctl = ALU_OR;
                    3'b010:  dec.alu_ctl = ALU_SLT;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                dec.illegal = 1'b0;
                dec.use_imm = 1'b1;
                fmt         = IMM_I;
                case (funct3)
                    3'b000:  dec.alu_ctl = ALU_ADD;
                    3'b111:  dec.alu_ctl = ALU_AND;
                    3'b110:  dec.alu_ctl = ALU_OR;
                    3'b010:  dec.alu_ctl = ALU_SLT;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    dec.illegal = 1'b0;
                    dec.use_imm = 1'b1;
                    dec.alu_ctl = ALU_ADD;
                    fmt         = IMM_I;
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b010) begin
                    dec.illegal = 1'b0;
                    dec.use_imm = 1'b1;
                    dec.alu_ctl = ALU_ADD;
                    fmt         = IMM_S;
                end
            end
            OP_BRANCH: begin
                if (funct3 == 3'b000 || funct3 == 3'b100) begin
                    dec.illegal   = 1'b0;
                    dec.is_branch = 1'b1;
                    dec.alu_ctl   = (funct3 == 3'b000) ? ALU_SUB : ALU_SLT;
                    fmt           = IMM_B;
                end
            end
            default: ;
        endcase

        // Any illegal combination collapses to the canonical illegal entry,
        // even if a legal-looking opcode already set partial fields.
        if (dec.illegal) begin
            dec.alu_ctl   = ALU_ILLEGAL;
            dec.use_imm   = 1'b0;
            dec.is_branch = 1'b0;
            fmt           = IMM_NONE;
        end
    end

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{(REG_WIDTH-12){instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{(REG_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{(REG_WIDTH-13){instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/riscv_alu_issue.sv
// riscv_alu_issue
// Decodes offered RV32I instructions and queues them in a 2-entry skid buffer
// ahead of the ALU stage.
//
// Ports:
//   clk, rst            : clock, async active-high reset
//   in_valid / in_ready : input handshake; in_ready is registered
//   in_instr            : instruction word
//   flush               : drop everything buffered and the current offer
//   out_valid/out_ready : output handshake
//   out_*               : decoded head entry
//
// Skid-buffer states:
//   state    | meaning
//   ---------+----------------------------------------------
//   ST_EMPTY | no entry held, out_valid=0
//   ST_ONE   | head entry valid in slot 0
//   ST_TWO   | both slots full, in_ready=0
module riscv_alu_issue
    import riscv_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_alu_ctl,
    output logic                 out_use_imm,
    output logic [REG_WIDTH-1:0] out_imm,
    output logic                 out_is_branch,
    output logic                 out_illegal,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [4:0]           out_rd
);

    dec_t                 dec_f;
    logic [REG_WIDTH-1:0] dec_imm;

    dec_t                 ent0, ent1;
    logic [REG_WIDTH-1:0] imm0, imm1;

    state_t state, state_nxt;
    logic   in_ready_q;
    logic   accept, pop;
    logic   ld0, ld1, shift;

    riscv_alu_decode #(.REG_WIDTH(REG_WIDTH)) u_decode (
        .instr (in_instr),
        .dec   (dec_f),
        .imm   (dec_imm)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != ST_TWO);
        end
    end

    always_comb begin
        state_nxt = state;
        ld0       = 1'b0;
        ld1       = 1'b0;
        shift     = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt = ST_ONE;
                        ld0       = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        ld0 = 1'b1;
                    end else if (accept) begin
                        state_nxt = ST_TWO;
                        ld1       = 1'b1;
                    end else if (pop) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_nxt = ST_ONE;
                        shift     = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0 <= '0;
            ent1 <= '0;
            imm0 <= '0;
            imm1 <= '0;
        end else begin
            if (ld0) begin
                ent0 <= dec_f;
                imm0 <= dec_imm;
            end else if (shift) begin
                ent0 <= ent1;
                imm0 <= imm1;
            end
            if (ld1) begin
                ent1 <= dec_f;
                imm1 <= dec_imm;
            end
        end
    end

    assign out_alu_ctl   = ent0.alu_ctl;
    assign out_use_imm   = ent0.use_imm;
    assign out_imm       = imm0;
    assign out_is_branch = ent0.is_branch;
    assign out_illegal   = ent0.illegal;
    assign out_rs1       = ent0.rs1;
    assign out_rs2       = ent0.rs2;
    assign out_rd        = ent0.rd;

endmodule

// File: tb/tb_riscv_alu_issue.sv
// tb_riscv_alu_issue
// Directed bench for riscv_alu_issue. Inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_riscv_alu_issue;

    localparam int REG_WIDTH = 32;

    localparam logic [31:0] I_SUB  = 32'h40208133; // sub  x2,x1,x2
    localparam logic [31:0] I_ADDI = 32'hFFF00293; // addi x5,x0,-1
    localparam logic [31:0] I_BAD  = 32'h0000007F;
    localparam logic [31:0] I_BLT  = 32'h0020C463; // blt  x1,x2,+8

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_instr;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0]           out_alu_ctl;
    logic                 out_use_imm;
    logic [REG_WIDTH-1:0] out_imm;
    logic                 out_is_branch;
    logic                 out_illegal;
    logic [4:0]           out_rs1;
    logic [4:0]           out_rs2;
    logic [4:0]           out_rd;

    int tests = 0;
    int fails = 0;

    riscv_alu_issue #(.REG_WIDTH(REG_WIDTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_alu_ctl   (out_alu_ctl),
        .out_use_imm   (out_use_imm),
        .out_imm       (out_imm),
        .out_is_branch (out_is_branch),
        .out_illegal   (out_illegal),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_rd        (out_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_in_ready",  in_ready,    0);
        check("rst_out_valid", out_valid,   0);
        check("rst_alu_ctl",   out_alu_ctl, 0);
        check("rst_imm",       out_imm,     0);
        check("rst_rd",        out_rd,      0);

        rst = 1'b0;
        tick();
        check("in_ready_after_rst", in_ready, 1);

        // SUB with downstream ready: visible one edge after accept
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = I_SUB;
        tick();
        in_valid = 1'b0;
        check("sub_valid",   out_valid,   1);
        check("sub_alu",     out_alu_ctl, 4'b0110);
        check("sub_rd",      out_rd,      2);
        check("sub_rs1",     out_rs1,     1);
        check("sub_rs2",     out_rs2,     2);
        check("sub_use_imm", out_use_imm, 0);
        check("sub_illegal", out_illegal, 0);
        tick();
        check("sub_popped", out_valid, 0);

        // ADDI -1
        in_valid = 1'b1;
        in_instr = I_ADDI;
        tick();
        in_valid = 1'b0;
        check("addi_alu",     out_alu_ctl, 4'b0010);
        check("addi_use_imm", out_use_imm, 1);
        check("addi_imm",     out_imm,     32'hFFFFFFFF);
        check("addi_rd",      out_rd,      5);
        tick();

        // Back-to-back stream: accept and pop together in ONE
        in_valid = 1'b1;
        in_instr = I_SUB;
        tick();
        check("stream_head0", out_alu_ctl, 4'b0110);
        in_instr = I_ADDI;
        tick();
        in_valid = 1'b0;
        check("stream_valid",    out_valid,   1);
        check("stream_head1",    out_alu_ctl, 4'b0010);
        check("stream_in_ready", in_ready,    1);
        tick();
        check("stream_drained", out_valid, 0);

        // Backpressure: fill both slots, third offer refused
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = I_BAD;
        tick();
        check("bp_one_in_ready", in_ready, 1);
        in_instr = I_BLT;
        tick();
        check("bp_two_in_ready", in_ready,    0);
        check("bp_head_illegal", out_illegal, 1);
        check("bp_head_alu",     out_alu_ctl, 4'b1111);
        check("bp_head_imm",     out_imm,     0);
        in_instr = I_ADDI;
        tick();
        check("bp_hold_illegal", out_illegal, 1);
        check("bp_hold_alu",     out_alu_ctl, 4'b1111);
        check("bp_hold_ready",   in_ready,    0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("blt_valid",   out_valid,     1);
        check("blt_alu",     out_alu_ctl,   4'b0111);
        check("blt_branch",  out_is_branch, 1);
        check("blt_imm",     out_imm,       8);
        check("blt_use_imm", out_use_imm,   0);
        check("blt_rs1",     out_rs1,       1);
        check("blt_rs2",     out_rs2,       2);
        check("blt_in_ready", in_ready,     1);
        tick();
        check("bp_no_third", out_valid, 0);

        // Flush in TWO with an offer present
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = I_SUB;
        tick();
        in_instr = I_ADDI;
        tick();
        check("fl_full", in_ready, 0);
        flush    = 1'b1;
        in_instr = I_BLT;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", out_valid, 0);
        check("fl_in_ready",  in_ready,  1);
        out_ready = 1'b1;
        tick();
        check("fl_nothing_delivered", out_valid, 0);

        // Async reset while in ONE
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = I_SUB;
        tick();
        in_valid = 1'b0;
        check("ar_one_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid_drop", out_valid,   0);
        check("ar_in_ready",   in_ready,    0);
        check("ar_alu_zero",   out_alu_ctl, 0);
        tick();
        rst = 1'b0;
        tick();
        check("ar_recover_ready", in_ready,  1);
        check("ar_recover_empty", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
